// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Bundles every request, response and memory-bus signal of the unified
// memory-port arbiter.
//
//   slave  modport : the arbiter itself.
//   master modport : everything around it (I-side fetch unit, D-side
//                    load/store unit and the memory), collapsed into one
//                    view.
//
// Signals:
//   i_valid/i_addr/i_ready                  I-side read request handshake
//   i_rsp_valid/i_rsp_data                  I-side response
//   d_valid/d_we/d_addr/d_wdata/d_wstrb     D-side request
//   d_ready                                 D-side accept
//   d_rsp_valid/d_rsp_data                  D-side response
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb, mem_ack/mem_rdata
//                                           memory port
//   busy                                    port occupied (stall control FSM)
//   i_rsp_err/d_rsp_err                     timeout flags, MEM_TIMEOUT_EN only
//
// Build macro: MEM_TIMEOUT_EN adds the two error flags.
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              i_valid;
   logic [ADDR_W-1:0] i_addr;
   logic              i_ready;
   logic              i_rsp_valid;
   logic [DATA_W-1:0] i_rsp_data;

   logic              d_valid;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [3:0]        d_wstrb;
   logic              d_ready;
   logic              d_rsp_valid;
   logic [DATA_W-1:0] d_rsp_data;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [3:0]        mem_wstrb;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   logic              busy;
`ifdef MEM_TIMEOUT_EN
   logic              i_rsp_err;
   logic              d_rsp_err;
`endif

   modport slave (
      input  i_valid, i_addr,
             d_valid, d_we, d_addr, d_wdata, d_wstrb,
             mem_ack, mem_rdata,
      output i_ready, i_rsp_valid, i_rsp_data,
             d_ready, d_rsp_valid, d_rsp_data,
             mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
             busy
`ifdef MEM_TIMEOUT_EN
      , output i_rsp_err, d_rsp_err
`endif
   );

   modport master (
      output i_valid, i_addr,
             d_valid, d_we, d_addr, d_wdata, d_wstrb,
             mem_ack, mem_rdata,
      input  i_ready, i_rsp_valid, i_rsp_data,
             d_ready, d_rsp_valid, d_rsp_data,
             mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
             busy
`ifdef MEM_TIMEOUT_EN
      , input i_rsp_err, d_rsp_err
`endif
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single memory port of the multi-cycle RV32I core between the
// instruction-fetch side (I) and the load/store side (D). One request is
// accepted at a time. It is held on the memory bus until mem_ack, and a
// registered one-cycle response is then returned to the side that issued
// it. Ties go round-robin; after reset the I-side wins the first tie.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    mem_port_arbiter_if.slave (requests, responses, memory port, busy)
//
// Parameters:
//   ADDR_W          address width
//   DATA_W          data width, must be 32 (four byte strobes)
//   TIMEOUT_CYCLES  bus cycles to wait for mem_ack (MEM_TIMEOUT_EN only)
//
// Build macro: MEM_TIMEOUT_EN enables the mem_ack timeout and the
// i_rsp_err/d_rsp_err flags. Without it the arbiter waits for mem_ack
// indefinitely.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input logic               clk,
   input logic               reset,
   mem_port_arbiter_if.slave bus
);

   if (DATA_W != 32 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
      $error("mem_port_arbiter: DATA_W must be 32 and TIMEOUT_CYCLES >= 1");
   end

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BUS_I = 2'd1;
   localparam logic [1:0] ST_BUS_D = 2'd2;
   localparam logic [1:0] ST_RSP   = 2'd3;

   logic [1:0]        state;
   // 1 = I-side owned the last accepted request, 0 = D-side.
   // It is written on every accept, so it also names the owner of the
   // request in flight.
   logic              last_grant_i;

   logic [ADDR_W-1:0] req_addr;
   logic              req_we;
   logic [DATA_W-1:0] req_wdata;
   logic [3:0]        req_wstrb;

   logic [DATA_W-1:0] i_data_q;
   logic [DATA_W-1:0] d_data_q;
   logic [DATA_W-1:0] cap_data;

   logic              idle;
   logic              in_bus;
   logic              grant_i;
   logic              grant_d;
   logic              tmo_hit;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0]  tmo_cnt;
   logic              i_err_q;
   logic              d_err_q;

   // The counter holds the number of bus cycles already spent without
   // mem_ack. It reaches TIMEOUT_CYCLES-1 in the last bus cycle allowed.
   assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   assign idle   = (state == ST_IDLE);
   assign in_bus = (state == ST_BUS_I) || (state == ST_BUS_D);

   // Round-robin: on a tie, the side that did not win last time is granted.
   assign grant_i = bus.i_valid && (!bus.d_valid || !last_grant_i);
   assign grant_d = bus.d_valid && !grant_i;

   assign bus.i_ready = idle && grant_i;
   assign bus.d_ready = idle && grant_d;

   // All memory outputs come from the request register, so the bus stays
   // stable whatever the requesters do after the accept.
   assign bus.mem_req   = in_bus;
   assign bus.mem_we    = req_we;
   assign bus.mem_addr  = req_addr;
   assign bus.mem_wdata = req_wdata;
   assign bus.mem_wstrb = req_wstrb;

   assign bus.i_rsp_valid = (state == ST_RSP) &&  last_grant_i;
   assign bus.d_rsp_valid = (state == ST_RSP) && !last_grant_i;
   assign bus.i_rsp_data  = i_data_q;
   assign bus.d_rsp_data  = d_data_q;
   assign bus.busy        = !idle;

`ifdef MEM_TIMEOUT_EN
   assign bus.i_rsp_err = bus.i_rsp_valid && i_err_q;
   assign bus.d_rsp_err = bus.d_rsp_valid && d_err_q;
`endif

   // Response word: read data on a completed read. It is zero for a store,
   // and also zero on a timeout because mem_ack is low then.
   always_comb begin
      // NOTE: assign the default first so every path drives cap_data and no latch is inferred.
      cap_data = '0;
      if (bus.mem_ack && !req_we) begin
         cap_data = bus.mem_rdata;
      end
   end

   // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= ST_IDLE;
         last_grant_i <= 1'b0;
         req_addr     <= '0;
         req_we       <= 1'b0;
         req_wdata    <= '0;
         req_wstrb    <= '0;
         i_data_q     <= '0;
         d_data_q     <= '0;
`ifdef MEM_TIMEOUT_EN
         tmo_cnt      <= '0;
         i_err_q      <= 1'b0;
         d_err_q      <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
`ifdef MEM_TIMEOUT_EN
               tmo_cnt <= '0;
`endif
               if (grant_i) begin
                  // Fetches are always plain reads.
                  req_addr     <= bus.i_addr;
                  req_we       <= 1'b0;
                  req_wdata    <= '0;
                  req_wstrb    <= '0;
                  last_grant_i <= 1'b1;
                  state        <= ST_BUS_I;
               end else if (grant_d) begin
                  req_addr     <= bus.d_addr;
                  req_we       <= bus.d_we;
                  req_wdata    <= bus.d_wdata;
                  req_wstrb    <= bus.d_we ? bus.d_wstrb : 4'b0000;
                  last_grant_i <= 1'b0;
                  state        <= ST_BUS_D;
               end
            end

            ST_BUS_I, ST_BUS_D: begin
               // mem_ack takes priority over a timeout in the same cycle.
               if (bus.mem_ack || tmo_hit) begin
                  if (state == ST_BUS_I) begin
                     i_data_q <= cap_data;
                  end else begin
                     d_data_q <= cap_data;
                  end
`ifdef MEM_TIMEOUT_EN
                  if (state == ST_BUS_I) begin
                     i_err_q <= !bus.mem_ack;
                  end else begin
                     d_err_q <= !bus.mem_ack;
                  end
`endif
                  state <= ST_RSP;
               end
`ifdef MEM_TIMEOUT_EN
               else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
`endif
            end

            ST_RSP:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single unified memory port of the multi-cycle RV32I core between the instruction-fetch requester (I-side) and the load/store requester (D-side). Accepts one request at a time, holds it on the memory bus until the memory acknowledges, and returns a registered response to the requester that issued it. Ties are resolved round-robin. `busy` is exported so the control FSM can stall while the port is occupied.

Parameters:
ADDR_W, 32, address width of requesters and memory port
DATA_W, 32, data width; must be 32 (4 byte strobes)
TIMEOUT_CYCLES, 255, max wait cycles for mem_ack (used only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
i_valid  in  1  I-side request pending
i_addr  in  ADDR_W  I-side read address
i_ready  out  1  I-side request accepted this cycle when i_valid && i_ready
i_rsp_valid  out  1  one-cycle pulse, I-side read data valid
i_rsp_data  out  DATA_W  I-side read data
d_valid  in  1  D-side request pending
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  D-side address
d_wdata  in  DATA_W  store data
d_wstrb  in  4  store byte enables
d_ready  out  1  D-side request accepted this cycle
d_rsp_valid  out  1  one-cycle pulse, load data valid or store complete
d_rsp_data  out  DATA_W  load data; 0 for stores
mem_req  out  1  memory request active
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_wstrb  out  4  memory byte enables; 0 for reads
mem_ack  in  1  memory completes the active request this cycle
mem_rdata  in  DATA_W  read data, valid with mem_ack
busy  out  1  high in any state other than IDLE
i_rsp_err / d_rsp_err  out  1  timeout flags; present only with MEM_TIMEOUT_EN

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE.
  - All outputs and registers are 0.
  - last_grant = D, so I-side wins the first tie.
  - An in-flight transaction is dropped; mem_req falls without waiting for a clock edge. No response is issued for it.
- States: IDLE, BUS_I, BUS_D, RSP.
- IDLE:
  - i_ready/d_ready are combinational and only ever high here.
  - Only one valid: that side gets ready.
  - Both valid: the side not equal to last_grant gets ready; the other side's ready = 0.
  - On accept edge: latch addr/we/wdata/wstrb into the request register, record owner, set last_grant = owner, go to BUS_I or BUS_D.
  - I-side requests are always reads (we=0, wstrb=0).
- BUS_I / BUS_D:
  - mem_req = 1; mem_* driven from the request register only and held stable until mem_ack.
  - On mem_ack edge: capture mem_rdata (or 0 if we=1) into the response register, go to RSP.
- RSP:
  - The owner's rsp_valid = 1 for exactly one cycle, then IDLE.
  - The other side's rsp_valid stays 0.
  - rsp_data holds its value until the next response to that side.
- Latency:
  - Accept at edge N, so mem_req is high from cycle N+1.
  - mem_ack in cycle N+k means rsp_valid in cycle N+k+1.
  - Next accept is possible in cycle N+k+2.
  - Minimum 3 cycles per transaction.
- Boundaries:
  - mem_ack while mem_req=0: ignored.
  - Requester drops valid before accept: nothing happens; no ready pulse is owed.
  - Requester changes inputs after accept: no effect on the bus.
  - Round-robin guarantees neither side waits more than one foreign transaction when both are continuously valid.
  - busy = (state != IDLE).

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - A counter clears on entry to BUS_I/BUS_D and increments every cycle without mem_ack.
  - When the count reaches TIMEOUT_CYCLES, mem_req drops and the block goes to RSP.
  - The owner gets rsp_valid with rsp_err = 1 and rsp_data = 0.
  - rsp_err is 0 on normal completion.
  - mem_ack on the same cycle as the timeout wins: normal completion, err = 0.
- Not defined: no counter, no err ports; the block waits for mem_ack indefinitely.

Test Plan:
1. Reset low mid-BUS_D (mem_req=1) -> mem_req=0 before the next clk edge; after release, busy=0, no d_rsp_valid.
2. Single fetch: i_valid=1, i_addr=0x0000_0040; mem_ack in the first bus cycle with mem_rdata=0x0051_0093 -> mem_addr=0x40, mem_wstrb=0; i_rsp_valid one cycle later with i_rsp_data=0x0051_0093; total 3 cycles.
3. Store: d_we=1, d_addr=0x100, d_wdata=0xCAFE_F00D, d_wstrb=4'b0011; memory waits 4 cycles -> mem_* stable all 4 cycles; d_rsp_valid with d_rsp_data=0.
4. Both valid from reset and held -> grant order I, D, I, D; i_ready/d_ready never high together.
5. Stray mem_ack pulse in IDLE, and d_valid dropped before grant -> no state change, no rsp pulses.
6. (MEM_TIMEOUT_EN, TIMEOUT_CYCLES=8) load with no mem_ack -> mem_req falls after 8 bus cycles; d_rsp_valid=1, d_rsp_err=1, d_rsp_data=0.
